// File: rtl/chess_turn_controller.sv
// Chess clock turn arbiter: synchronises and debounces the player/pause buttons,
// then runs the game FSM that enables one player's countdown timer at a time.
module chess_turn_controller #(
    parameter int DEBOUNCE_CYCLES  = 500000,
    parameter int MOVE_COUNT_WIDTH = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        btn_white,
    input  logic                        btn_black,
    input  logic                        btn_pause,
    input  logic                        timeout_white,
    input  logic                        timeout_black,
    output logic                        flag_white,
    output logic                        flag_black,
    output logic                        paused,
    output logic                        game_over,
    output logic                        winner,
    output logic [MOVE_COUNT_WIDTH-1:0] move_count
);
    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WHITE_RUN,
        S_BLACK_RUN,
        S_PAUSED,
        S_OVER
    } state_t;

    // Button lanes: [0] white, [1] black, [2] pause
    logic [2:0]       w_raw;
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_deb;
    logic [2:0]       r_deb_d;
    logic [CNT_W-1:0] r_cnt [0:2];
    logic [2:0]       w_press;

    state_t                      r_state;
    state_t                      w_state_next;
    logic                        r_resume_black;
    logic                        w_resume_next;
    logic                        r_winner;
    logic                        w_winner_next;
    logic [MOVE_COUNT_WIDTH-1:0] r_move_count;
    logic [MOVE_COUNT_WIDTH-1:0] w_move_next;
    logic [MOVE_COUNT_WIDTH-1:0] w_move_inc;

    assign w_raw = {btn_pause, btn_black, btn_white};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_d <= '0;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            // Any bounce back to the accepted level restarts the stability count
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] != r_deb[i]) begin
                    if (r_cnt[i] == CNT_MAX) begin
                        r_deb[i] <= r_sync2[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_press    = r_deb & ~r_deb_d;
    assign w_move_inc = (r_move_count == '1) ? r_move_count : r_move_count + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_resume_black <= 1'b0;
            r_winner       <= 1'b0;
            r_move_count   <= '0;
        end else begin
            r_state        <= w_state_next;
            r_resume_black <= w_resume_next;
            r_winner       <= w_winner_next;
            r_move_count   <= w_move_next;
        end
    end

    // Within a cycle: timeout beats a move press, which beats pause
    always_comb begin
        w_state_next  = r_state;
        w_resume_next = r_resume_black;
        w_winner_next = r_winner;
        w_move_next   = r_move_count;
        case (r_state)
            S_IDLE: begin
                if (w_press[1]) begin
                    w_state_next = S_WHITE_RUN;
                end
            end
            S_WHITE_RUN: begin
                if (timeout_white) begin
                    w_state_next  = S_OVER;
                    w_winner_next = 1'b1;
                end else if (w_press[0]) begin
                    w_state_next = S_BLACK_RUN;
                    w_move_next  = w_move_inc;
                end else if (w_press[2]) begin
                    w_state_next  = S_PAUSED;
                    w_resume_next = 1'b0;
                end
            end
            S_BLACK_RUN: begin
                if (timeout_black) begin
                    w_state_next  = S_OVER;
                    w_winner_next = 1'b0;
                end else if (w_press[1]) begin
                    w_state_next = S_WHITE_RUN;
                    w_move_next  = w_move_inc;
                end else if (w_press[2]) begin
                    w_state_next  = S_PAUSED;
                    w_resume_next = 1'b1;
                end
            end
            S_PAUSED: begin
                if (w_press[2]) begin
                    w_state_next = r_resume_black ? S_BLACK_RUN : S_WHITE_RUN;
                end
            end
            S_OVER: begin
                w_state_next = S_OVER;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign flag_white = (r_state == S_WHITE_RUN);
    assign flag_black = (r_state == S_BLACK_RUN);
    assign paused     = (r_state == S_PAUSED);
    assign game_over  = (r_state == S_OVER);
    assign winner     = r_winner;
    assign move_count = r_move_count;
endmodule

// File: tb/tb_chess_turn_controller.sv
// Scoreboarded bench for chess_turn_controller with a game-level reference model
// (debounce window of 4, two-bit move counter).
module tb_chess_turn_controller;
    localparam int D  = 4;
    localparam int MW = 2;
    localparam int MC_MAX = (1 << MW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          btn_white, btn_black, btn_pause;
    logic          timeout_white, timeout_black;
    logic          flag_white, flag_black, paused, game_over, winner;
    logic [MW-1:0] move_count;

    int checks = 0;
    int errors = 0;

    logic [6:0] exp_q [$];

    chess_turn_controller #(.DEBOUNCE_CYCLES(D), .MOVE_COUNT_WIDTH(MW)) dut (
        .clock(clock), .reset(reset),
        .btn_white(btn_white), .btn_black(btn_black), .btn_pause(btn_pause),
        .timeout_white(timeout_white), .timeout_black(timeout_black),
        .flag_white(flag_white), .flag_black(flag_black), .paused(paused),
        .game_over(game_over), .winner(winner), .move_count(move_count)
    );

    always #5 clock = ~clock;

    // Reference model: game described as started/over/paused/side-to-move
    bit m_started, m_over, m_paused, m_side, m_winner;
    int m_moves;
    bit s1m [3];
    bit s2m [3];
    bit acc [3];
    bit prs [3];
    bit hist [3][$];

    function automatic logic [6:0] model_out();
        bit running;
        running = m_started && !m_over && !m_paused;
        return {running && !m_side, running && m_side, m_paused && !m_over,
                m_over, m_winner, 2'(m_moves)};
    endfunction

    function automatic void model_step();
        bit raw [3];
        bit seen, all_same;
        raw = '{btn_white, btn_black, btn_pause};
        if (reset) begin
            m_started = 0; m_over = 0; m_paused = 0; m_side = 0; m_winner = 0; m_moves = 0;
            for (int b = 0; b < 3; b++) begin
                s1m[b] = 0; s2m[b] = 0; acc[b] = 0; prs[b] = 0;
                hist[b].delete();
                for (int k = 0; k < D; k++) hist[b].push_back(1'b0);
            end
            return;
        end
        if (!m_started) begin
            if (prs[1]) begin m_started = 1; m_side = 0; end
        end else if (m_over) begin
        end else if (m_paused) begin
            if (prs[2]) m_paused = 0;
        end else begin
            if (m_side ? timeout_black : timeout_white) begin
                m_over = 1;
                m_winner = !m_side;
            end else if (m_side ? prs[1] : prs[0]) begin
                m_side = !m_side;
                if (m_moves < MC_MAX) m_moves++;
            end else if (prs[2]) begin
                m_paused = 1;
            end
        end
        // A level is accepted once the last D synchronised samples all disagree with it
        for (int b = 0; b < 3; b++) begin
            seen = s2m[b];
            hist[b].push_back(seen);
            void'(hist[b].pop_front());
            all_same = 1;
            foreach (hist[b][k]) if (hist[b][k] != !acc[b]) all_same = 0;
            prs[b] = 0;
            if (all_same) begin
                acc[b] = !acc[b];
                prs[b] = acc[b];
            end
            s2m[b] = s1m[b];
            s1m[b] = raw[b];
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        model_step();
        exp_q.push_back(model_out());
        #1;
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            logic [6:0] e, a;
            e = exp_q.pop_front();
            a = {flag_white, flag_black, paused, game_over, winner, move_count};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL scoreboard t=%0t outputs fw,fb,p,go,w,mc got=%b want=%b", $time, a, e);
            end
        end
    end

    task automatic check_eq(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    task automatic press(input int which);
        case (which)
            0: btn_white = 1'b1;
            1: btn_black = 1'b1;
            default: btn_pause = 1'b1;
        endcase
        repeat (8) tick();
        btn_white = 1'b0; btn_black = 1'b0; btn_pause = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        reset = 1'b1;
        btn_white = 0; btn_black = 0; btn_pause = 0;
        timeout_white = 0; timeout_black = 0;
        repeat (2) tick();
        check_eq("reset_outputs", {flag_white, flag_black, paused, game_over, winner, move_count}, 0);
        reset = 1'b0;

        // 1: start, white's clock runs 7 edges after the black rise
        btn_black = 1'b1;
        repeat (6) tick();
        check_eq("start_edge6_flag_white", flag_white, 0);
        tick();
        check_eq("start_edge7_flag_white", flag_white, 1);
        check_eq("start_flag_black", flag_black, 0);
        check_eq("start_move_count", move_count, 0);
        repeat (3) tick();
        btn_black = 1'b0;
        repeat (8) tick();

        // 2: bouncing white button, then a clean hold
        btn_white = 1'b0;
        for (int i = 0; i < 6; i++) begin
            btn_white = ~btn_white;
            repeat (2) tick();
            check_eq("bounce_flag_white", flag_white, 1);
        end
        btn_white = 1'b1;
        repeat (10) tick();
        check_eq("bounce_flag_black", flag_black, 1);
        check_eq("bounce_move_count", move_count, 1);
        btn_white = 1'b0;
        repeat (8) tick();

        // 3: pause and resume from white's turn
        press(1);
        check_eq("white_turn_again", flag_white, 1);
        press(2);
        check_eq("paused", paused, 1);
        check_eq("paused_flags", {flag_white, flag_black}, 0);
        press(0);
        check_eq("paused_ignores_white", paused, 1);
        press(2);
        check_eq("resume_flag_white", flag_white, 1);
        check_eq("resume_move_count", move_count, 2);

        // 4: black timeout coinciding with black's accepted press
        press(0);
        check_eq("black_turn", flag_black, 1);
        btn_black = 1'b1;
        repeat (6) tick();
        timeout_black = 1'b1;
        tick();
        check_eq("timeout_game_over", game_over, 1);
        check_eq("timeout_winner", winner, 0);
        check_eq("timeout_move_count", move_count, 3);
        timeout_black = 1'b0;
        repeat (3) tick();
        btn_black = 1'b0;
        repeat (8) tick();
        press(0);
        press(2);
        check_eq("over_sticky", {game_over, winner, flag_white, flag_black}, 4'b1000);

        // 5: saturation of the move counter, then reset mid-game
        reset = 1'b1; tick(); reset = 1'b0;
        press(1);
        for (int i = 0; i < 5; i++) begin
            press((i % 2 == 0) ? 0 : 1);
            check_eq("sat_move_count", move_count, (i < 3) ? i + 1 : 3);
        end
        check_eq("sat_black_run", flag_black, 1);
        reset = 1'b1; tick();
        check_eq("midgame_reset", {flag_white, flag_black, paused, game_over, winner, move_count}, 0);

        // 6: black held through reset is a fresh press after release
        btn_black = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (6) tick();
        check_eq("held_edge6_flag_white", flag_white, 0);
        tick();
        check_eq("held_edge7_flag_white", flag_white, 1);
        btn_black = 1'b0;
        repeat (8) tick();

        // Randomised play
        for (int seg = 0; seg < 300; seg++) begin
            logic [2:0] b;
            b = 3'($urandom);
            btn_white = b[0]; btn_black = b[1]; btn_pause = b[2];
            timeout_white = ($urandom_range(0, 29) == 0);
            timeout_black = ($urandom_range(0, 29) == 0);
            reset = ($urandom_range(0, 39) == 0);
            if (reset) tick();
            reset = 1'b0;
            repeat ($urandom_range(1, 12)) tick();
        end
        btn_white = 0; btn_black = 0; btn_pause = 0;
        timeout_white = 0; timeout_black = 0;
        tick();

        @(negedge clock);
        #1;
        check_eq("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=running want=finished");
        $fatal(1);
    end
endmodule
